semaphore_unit: RTL and testbench
=================================

SEMAPHORE_UNIT -- requirements
Module: semaphore_unit

Interface
REQ-001 Parameter NUM_CORES, default 4, SHALL set the number of CPU cores served; the legal range is 2..8.
REQ-002 Parameter SEM_BITS, default 4, SHALL set the semaphore ID width; the table holds 2^SEM_BITS entries.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 CPU_Reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 SEMAPHORE_EN  input  NUM_CORES  SHALL carry the per-core request strobe; it is held high until ACK is seen.
REQ-006 SEMAPHORE_CREATE  input  NUM_CORES  SHALL carry the per-core create opcode bit.
REQ-007 SEMAPHORE_ACQUIRE  input  NUM_CORES  SHALL carry the per-core acquire opcode bit.
REQ-008 SEMAPHORE_RELEASE  input  NUM_CORES  SHALL carry the per-core release opcode bit.
REQ-009 SEMAPHORE_ID  input  NUM_CORES*SEM_BITS  SHALL carry the per-core semaphore ID; core k uses slice [k*SEM_BITS +: SEM_BITS].
REQ-010 SEMAPHORE_ACK  output  NUM_CORES  SHALL carry the per-core acknowledge; it is one-hot or zero.
REQ-011 SEMAPHORE_RESULT  output  NUM_CORES  SHALL carry the per-core result bit; it is valid while the matching ACK bit is high.

Function
REQ-012 Each table entry SHALL hold a created bit, a locked bit and a $clog2(NUM_CORES)-bit owner field.
REQ-013 The FSM SHALL have four states, IDLE, EXEC, ACK and RELEASE_WAIT, with these transitions:
- IDLE -> EXEC when any EN bit is high;
- EXEC -> ACK unconditionally;
- ACK -> RELEASE_WAIT unconditionally;
- RELEASE_WAIT -> IDLE when EN of the granted core is low.
REQ-014 In IDLE the arbiter SHALL grant round-robin: the first core with EN high, searching upward from pointer rr_ptr and wrapping from NUM_CORES-1 to 0.
REQ-015 On IDLE->EXEC the unit SHALL latch the granted core index, its opcode bits and its ID; later input changes are ignored until IDLE.
REQ-016 In EXEC the unit SHALL update the table entry and register the result, as follows:
- CREATE: if the entry is not created, set created=1 and locked=0, result=1; otherwise no change, result=0.
- ACQUIRE: if created and not locked, set locked=1 and owner=core, result=1; if locked by the same core, no change, result=1; otherwise result=0 (non-blocking; the core retries).
- RELEASE: if locked and owner==core, clear locked, result=1; otherwise no change, result=0 (see REQ-024 and REQ-025).
- Operation on an entry that is not created: no change, result=0.
- Zero or more than one opcode bit set: no change, result=0, ACK still issued.
REQ-017 SEMAPHORE_ACK[granted] and SEMAPHORE_RESULT[granted] SHALL go high in ACK and stay stable through RELEASE_WAIT; all other bits are 0.
REQ-018 Latency from EN high in IDLE to ACK high SHALL be 2 cycles.
REQ-019 On RELEASE_WAIT->IDLE the unit SHALL set ACK and RESULT to 0 and set rr_ptr to granted+1, modulo NUM_CORES.
REQ-020 A core's EN that stays high after its ACK SHALL NOT be re-granted until the unit has returned to IDLE.
REQ-021 The unit SHALL service exactly one request per transaction; losing requestors wait with no lost state.

Reset
REQ-022 While CPU_Reset is 0 on a clock edge, the unit SHALL:
- set state=IDLE and rr_ptr=0;
- set ACK=0 and RESULT=0;
- clear created, locked and owner in every table entry.
REQ-023 A reset during EXEC, ACK or RELEASE_WAIT SHALL abort the transaction with no table update and no ACK.

Configuration
REQ-024 With macro SEMAPHORE_OWNER_CHECK_EN defined, RELEASE SHALL succeed only when owner==core; a non-owner RELEASE returns result=0 and leaves the entry unchanged.
REQ-025 Without SEMAPHORE_OWNER_CHECK_EN, RELEASE SHALL clear locked for any requesting core when the entry is locked (result=1); the owner comparator is not built.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Core0 CREATE ID 3 -> ACK[0] at cycle 2, RESULT[0]=1; second CREATE ID 3 -> RESULT[0]=0.
- Core1 ACQUIRE ID 3 -> RESULT=1; then core2 ACQUIRE ID 3 -> RESULT=0; core1 RELEASE; core2 ACQUIRE ID 3 -> RESULT=1.
- Cores 0,1,2,3 raise EN together with rr_ptr=0, each dropping EN after its ACK -> ACKs in order 0,1,2,3; next simultaneous round starts at core 0.
- Core3 ACQUIRE ID 5 with ID 5 not created -> RESULT=0; table unchanged.
- Core2 RELEASE ID 3 owned by core1 -> RESULT=0 with SEMAPHORE_OWNER_CHECK_EN, RESULT=1 (unlocked) without it.
- CPU_Reset=0 asserted in ACK state -> next cycle ACK=0; subsequent ACQUIRE ID 3 -> RESULT=0 (table cleared).

Source files
------------

// File: rtl/semaphore_unit.sv
// Hardware semaphore table shared by NUM_CORES cores, one round-robin-arbitrated transaction at a time.
// Optional feature macro: SEMAPHORE_OWNER_CHECK_EN (restricts RELEASE to the owning core).
module semaphore_unit #(
  parameter int NUM_CORES = 4,
  parameter int SEM_BITS  = 4
) (
  input  logic                          CLK,
  input  logic                          CPU_Reset,
  input  logic [NUM_CORES-1:0]          SEMAPHORE_EN,
  input  logic [NUM_CORES-1:0]          SEMAPHORE_CREATE,
  input  logic [NUM_CORES-1:0]          SEMAPHORE_ACQUIRE,
  input  logic [NUM_CORES-1:0]          SEMAPHORE_RELEASE,
  input  logic [NUM_CORES*SEM_BITS-1:0] SEMAPHORE_ID,
  output logic [NUM_CORES-1:0]          SEMAPHORE_ACK,
  output logic [NUM_CORES-1:0]          SEMAPHORE_RESULT
);

  localparam int IDX_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int ENTRIES = 1 << SEM_BITS;
  localparam logic [IDX_W:0] NC = (IDX_W+1)'(NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ACK,
    S_RELEASE_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       gnt_q;
  logic                   op_create_q, op_acquire_q, op_release_q;
  logic [SEM_BITS-1:0]    id_q;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [NUM_CORES-1:0]   result_q, result_d;

  logic                   created_q [ENTRIES];
  logic                   locked_q  [ENTRIES];
  logic [IDX_W-1:0]       owner_q   [ENTRIES];

  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W:0]         cand_sum;
  logic [IDX_W:0]         gnt_inc;

  logic                   ent_created, ent_locked;
  logic [IDX_W-1:0]       ent_owner;
  logic                   exec_res;
  logic                   set_created, set_locked, clr_locked;

  // Round-robin search upward from rr_ptr, wrapping at NUM_CORES
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_sum  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand_sum >= NC) begin
        cand_sum = cand_sum - NC;
      end
      if (!arb_found && SEMAPHORE_EN[cand_sum[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  // Table operation evaluated against the latched request
  always_comb begin
    ent_created = created_q[id_q];
    ent_locked  = locked_q[id_q];
    ent_owner   = owner_q[id_q];
    exec_res    = 1'b0;
    set_created = 1'b0;
    set_locked  = 1'b0;
    clr_locked  = 1'b0;
    case ({op_create_q, op_acquire_q, op_release_q})
      3'b100: begin
        if (!ent_created) begin
          set_created = 1'b1;
          exec_res    = 1'b1;
        end
      end
      3'b010: begin
        if (ent_created && !ent_locked) begin
          set_locked = 1'b1;
          exec_res   = 1'b1;
        end else if (ent_created && ent_locked && (ent_owner == gnt_q)) begin
          exec_res   = 1'b1;
        end
      end
      3'b001: begin
`ifdef SEMAPHORE_OWNER_CHECK_EN
        if (ent_created && ent_locked && (ent_owner == gnt_q)) begin
          clr_locked = 1'b1;
          exec_res   = 1'b1;
        end
`else
        if (ent_created && ent_locked) begin
          clr_locked = 1'b1;
          exec_res   = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt_inc = {1'b0, gnt_q} + (IDX_W+1)'(1);
    if (gnt_inc == NC) begin
      gnt_inc = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    ack_d    = ack_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d         = S_ACK;
        ack_d           = '0;
        result_d        = '0;
        ack_d[gnt_q]    = 1'b1;
        result_d[gnt_q] = exec_res;
      end
      S_ACK: begin
        state_d = S_RELEASE_WAIT;
      end
      S_RELEASE_WAIT: begin
        if (!SEMAPHORE_EN[gnt_q]) begin
          state_d  = S_IDLE;
          ack_d    = '0;
          result_d = '0;
          rr_ptr_d = gnt_inc[IDX_W-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CPU_Reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      ack_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      result_q <= result_d;
    end
  end

  // Request capture; held until the unit returns to IDLE
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && arb_found) begin
      gnt_q        <= arb_idx;
      op_create_q  <= SEMAPHORE_CREATE[arb_idx];
      op_acquire_q <= SEMAPHORE_ACQUIRE[arb_idx];
      op_release_q <= SEMAPHORE_RELEASE[arb_idx];
      id_q         <= SEMAPHORE_ID[arb_idx*SEM_BITS +: SEM_BITS];
    end
  end

  always_ff @(posedge CLK) begin
    if (!CPU_Reset) begin
      for (int e = 0; e < ENTRIES; e++) begin
        created_q[e] <= 1'b0;
        locked_q[e]  <= 1'b0;
        owner_q[e]   <= '0;
      end
    end else if (state_q == S_EXEC) begin
      if (set_created) begin
        created_q[id_q] <= 1'b1;
        locked_q[id_q]  <= 1'b0;
      end
      if (set_locked) begin
        locked_q[id_q] <= 1'b1;
        owner_q[id_q]  <= gnt_q;
      end
      if (clr_locked) begin
        locked_q[id_q] <= 1'b0;
      end
    end
  end

  assign SEMAPHORE_ACK    = ack_q;
  assign SEMAPHORE_RESULT = result_q;

endmodule

// File: tb/tb_semaphore_unit.sv
// Directed bench for semaphore_unit (4 cores, 16 entries); expectations hand-computed per step.
module tb_semaphore_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en, cr, aq, rl;
  logic [15:0] id;
  logic [3:0]  ack, res;

  int checks = 0;
  int errors = 0;

`ifdef SEMAPHORE_OWNER_CHECK_EN
  localparam logic OWN = 1'b1;
`else
  localparam logic OWN = 1'b0;
`endif

  semaphore_unit #(.NUM_CORES(4), .SEM_BITS(4)) dut (
    .CLK              (clk),
    .CPU_Reset        (rst_n),
    .SEMAPHORE_EN     (en),
    .SEMAPHORE_CREATE (cr),
    .SEMAPHORE_ACQUIRE(aq),
    .SEMAPHORE_RELEASE(rl),
    .SEMAPHORE_ID     (id),
    .SEMAPHORE_ACK    (ack),
    .SEMAPHORE_RESULT (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-core transaction with exact latency checks; returns with the unit back in IDLE.
  task automatic do_op(input int core, input logic [2:0] op, input logic [3:0] sid,
                       input logic exp_res, input string tag);
    @(negedge clk);
    en[core] = 1'b1;
    cr[core] = op[2];
    aq[core] = op[1];
    rl[core] = op[0];
    id[core*4 +: 4] = sid;
    @(negedge clk);
    chk({tag, "_lat1"}, 32'(ack), 32'd0);
    @(negedge clk);
    chk({tag, "_ack"}, 32'(ack), 32'd1 << core);
    chk({tag, "_res"}, 32'(res), 32'(exp_res) << core);
    en[core] = 1'b0;
    cr[core] = 1'b0;
    aq[core] = 1'b0;
    rl[core] = 1'b0;
    @(negedge clk);
    chk({tag, "_hold"}, 32'(ack), 32'd1 << core);
    @(negedge clk);
    chk({tag, "_clr"}, 32'(ack), 32'd0);
  endtask

  // All four cores CREATE IDs 8..11 at once; grants must come out 0,1,2,3.
  task automatic rr_round(input logic exp_res, input string tag);
    int waited;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      en[c] = 1'b1;
      cr[c] = 1'b1;
      id[c*4 +: 4] = 4'(8 + c);
    end
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      while (ack == 4'd0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      chk({tag, "_wait"}, 32'(waited < 20), 32'd1);
      chk({tag, "_ack"}, 32'(ack), 32'd1 << n);
      chk({tag, "_res"}, 32'(res), 32'(exp_res) << n);
      en[n] = 1'b0;
      cr[n] = 1'b0;
      waited = 0;
      while (ack != 4'd0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = '0; cr = '0; aq = '0; rl = '0; id = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    rst_n = 1'b1;

    do_op(0, 3'b100, 4'd3, 1'b1, "c0_create3");
    do_op(0, 3'b100, 4'd3, 1'b0, "c0_create3_again");

    do_op(1, 3'b010, 4'd3, 1'b1, "c1_acq3");
    do_op(2, 3'b010, 4'd3, 1'b0, "c2_acq3_busy");
    do_op(1, 3'b010, 4'd3, 1'b1, "c1_acq3_reentry");
    do_op(1, 3'b001, 4'd3, 1'b1, "c1_rel3");
    do_op(2, 3'b010, 4'd3, 1'b1, "c2_acq3");

    do_op(3, 3'b010, 4'd5, 1'b0, "c3_acq5_uncreated");
    do_op(3, 3'b100, 4'd5, 1'b1, "c3_create5");

    rr_round(1'b1, "rr1");
    rr_round(1'b0, "rr2");

    do_op(2, 3'b001, 4'd3, 1'b1, "c2_rel3_owner");
    do_op(1, 3'b010, 4'd3, 1'b1, "c1_acq3_again");
    do_op(2, 3'b001, 4'd3, !OWN, "c2_rel3_nonowner");
    do_op(2, 3'b010, 4'd3, !OWN, "c2_acq3_after");

    do_op(1, 3'b110, 4'd7, 1'b0, "c1_multi_op");
    do_op(1, 3'b000, 4'd7, 1'b0, "c1_no_op");
    do_op(1, 3'b100, 4'd7, 1'b1, "c1_create7");

    @(negedge clk);
    en[0] = 1'b1;
    aq[0] = 1'b1;
    id[3:0] = 4'd5;
    @(negedge clk);
    @(negedge clk);
    chk("rstack_ack", 32'(ack), 32'd1);
    rst_n = 1'b0;
    en[0] = 1'b0;
    aq[0] = 1'b0;
    @(negedge clk);
    chk("rstack_ack_clr", 32'(ack), 32'd0);
    chk("rstack_res_clr", 32'(res), 32'd0);
    rst_n = 1'b1;
    do_op(0, 3'b010, 4'd3, 1'b0, "post_rst_acq3");
    do_op(0, 3'b010, 4'd5, 1'b0, "post_rst_acq5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
